// File: rtl/conv1_weight_loader.sv
// conv1 weight loader: captures the 150-word serial kernel stream into an on-chip
// buffer and serves one packed 5-tap kernel row per read to the MAC array.
module conv1_weight_loader #(
    parameter int unsigned DW  = 9,
    parameter int unsigned KS  = 5,
    parameter int unsigned NCH = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 w_valid,
    input  logic signed [DW-1:0] w_data,
    output logic                 w_ready,
    output logic                 load_busy,
    output logic                 load_done,
    output logic signed [DW+7:0] w_sum,
    input  logic                 rd_en,
    input  logic [2:0]           rd_ch,
    input  logic [2:0]           rd_row,
    output logic [KS*DW-1:0]     rd_data,
    output logic                 rd_valid,
    output logic                 rd_err
);

    localparam int unsigned SW   = DW + 8;
    localparam int unsigned NROW = NCH * KS;
    localparam int unsigned AW   = $clog2(NROW);
    localparam int unsigned CW   = 3;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t            state_q;
    logic [CW-1:0]     col_q, row_q, ch_q;
    logic [CW-1:0]     col_d, row_d, ch_d;
    logic [SW-1:0]     w_sum_q;
    logic [KS*DW-1:0]  rd_data_q;
    logic              rd_valid_q, rd_err_q;

    logic [DW-1:0]     mem_q [NROW][KS];

    logic              accept, last_col, last_row, last_word, rd_ok;
    logic [AW-1:0]     wr_addr, rd_addr;
    logic [KS*DW-1:0]  rd_row_c;

    assign w_ready   = (state_q == LOAD) && !start;
    assign load_busy = (state_q == LOAD);
    assign load_done = (state_q == DONE);
    assign w_sum     = w_sum_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_err    = rd_err_q;

    // Stream position bookkeeping and read address decode.
    always_comb begin
        accept    = w_valid && w_ready;
        last_col  = (col_q == CW'(KS - 1));
        last_row  = (row_q == CW'(KS - 1));
        last_word = last_col && last_row && (ch_q == CW'(NCH - 1));
        col_d     = last_col ? '0 : col_q + CW'(1);
        row_d     = row_q;
        ch_d      = ch_q;
        if (last_col) begin
            row_d = last_row ? '0 : row_q + CW'(1);
            if (last_row) begin
                ch_d = ch_q + CW'(1);
            end
        end
        wr_addr = AW'(ch_q) * AW'(KS) + AW'(row_q);
        rd_addr = AW'(rd_ch) * AW'(KS) + AW'(rd_row);
        rd_ok   = (state_q == DONE) && (rd_ch < CW'(NCH)) && (rd_row < CW'(KS));
    end

    // Column 0 goes to the most significant tap slot.
    always_comb begin
        rd_row_c = '0;
        for (int c = 0; c < int'(KS); c++) begin
            rd_row_c[(int'(KS) - 1 - c) * int'(DW) +: DW] = mem_q[rd_addr][c];
        end
    end

    // Buffer has no reset; contents are only meaningful once DONE is reached.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_addr][col_q] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            ch_q       <= '0;
            w_sum_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= LOAD;
                        col_q   <= '0;
                        row_q   <= '0;
                        ch_q    <= '0;
                        w_sum_q <= '0;
                    end
                end
                LOAD: begin
                    if (start) begin
                        col_q   <= '0;
                        row_q   <= '0;
                        ch_q    <= '0;
                        w_sum_q <= '0;
                    end else if (accept) begin
                        w_sum_q <= w_sum_q + {{(SW - DW){w_data[DW-1]}}, w_data};
                        if (last_word) begin
                            state_q <= DONE;
                            col_q   <= '0;
                            row_q   <= '0;
                            ch_q    <= '0;
                        end else begin
                            col_q <= col_d;
                            row_q <= row_d;
                            ch_q  <= ch_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            rd_valid_q <= rd_en && rd_ok;
            rd_err_q   <= rd_en && !rd_ok;
            if (rd_en && rd_ok) begin
                rd_data_q <= rd_row_c;
            end
        end
    end

endmodule

// File: tb/tb_conv1_weight_loader.sv
// Directed self-checking bench for conv1_weight_loader.
module tb_conv1_weight_loader;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               w_valid;
    logic signed [8:0]  w_data;
    logic               w_ready;
    logic               load_busy;
    logic               load_done;
    logic signed [16:0] w_sum;
    logic               rd_en;
    logic [2:0]         rd_ch;
    logic [2:0]         rd_row;
    logic [44:0]        rd_data;
    logic               rd_valid;
    logic               rd_err;

    int checks = 0;
    int errors = 0;
    logic [8:0] expw [150];

    conv1_weight_loader #(.DW(9), .KS(5), .NCH(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .w_valid(w_valid), .w_data(w_data),
        .w_ready(w_ready), .load_busy(load_busy), .load_done(load_done), .w_sum(w_sum),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_row(rd_row), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [44:0] exp_row(input int ch, input int row);
        logic [44:0] r;
        int b;
        b = (ch * 5 + row) * 5;
        r = {expw[b], expw[b+1], expw[b+2], expw[b+3], expw[b+4]};
        return r;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // mode 0: word n = n-75; mode 1: constant -3. Counts accepts seen by the bench.
    task automatic stream(input int mode, input bit toggle, input int max_acc, output int acc);
        int cyc;
        int v;
        acc = 0;
        cyc = 0;
        while (acc < max_acc && cyc < 1000) begin
            v = (mode == 0) ? acc - 75 : -3;
            w_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            w_data  = 9'(v);
            #1;
            if (w_valid && w_ready) begin
                expw[acc] = 9'(v);
                acc++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        w_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; w_valid = 0; w_data = 0; rd_en = 0; rd_ch = 0; rd_row = 0;
        tick(); tick();
        checks++;
        if ({w_ready, load_busy, load_done, rd_valid, rd_err} !== 5'b0 || w_sum !== 17'sd0
            || rd_data !== 45'd0) begin
            errors++;
            $display("FAIL reset: flags=%b w_sum=%0d rd_data=%h expected all zero",
                     {w_ready, load_busy, load_done, rd_valid, rd_err}, w_sum, rd_data);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_read_before_load();
        rd_en = 1'b1; rd_ch = 0; rd_row = 0;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_err !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 45'd0) begin
            errors++;
            $display("FAIL idle_read: rd_err=%b rd_valid=%b rd_data=%h expected 1 0 0",
                     rd_err, rd_valid, rd_data);
        end
        tick();
        checks++;
        if (rd_err !== 1'b0) begin
            errors++;
            $display("FAIL idle_read_pulse: rd_err=%b expected 0", rd_err);
        end
    endtask

    task automatic test_full_load();
        int acc;
        pulse_start();
        checks++;
        if (load_busy !== 1'b1 || w_sum !== 17'sd0) begin
            errors++;
            $display("FAIL start_idle: load_busy=%b w_sum=%0d expected 1 0", load_busy, w_sum);
        end
        stream(0, 1'b0, 150, acc);
        checks++;
        if (acc !== 150 || load_done !== 1'b1 || load_busy !== 1'b0 || w_sum !== -17'sd75) begin
            errors++;
            $display("FAIL full_load: acc=%0d done=%b busy=%b w_sum=%0d expected 150 1 0 -75",
                     acc, load_done, load_busy, w_sum);
        end
        rd_en = 1'b1; rd_ch = 0; rd_row = 0;
        tick();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== {9'h1B5, 9'h1B6, 9'h1B7, 9'h1B8, 9'h1B9}) begin
            errors++;
            $display("FAIL read_c0r0: valid=%b data=%h expected 1 cols -75..-71", rd_valid, rd_data);
        end
        rd_ch = 5; rd_row = 4;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== {9'd70, 9'd71, 9'd72, 9'd73, 9'd74}) begin
            errors++;
            $display("FAIL read_c5r4: valid=%b data=%h expected 1 cols 70..74", rd_valid, rd_data);
        end
        tick();
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_valid_idle: rd_valid=%b expected 0", rd_valid);
        end
    endtask

    task automatic test_bad_index();
        logic [44:0] prev;
        prev = rd_data;
        rd_en = 1'b1; rd_ch = 6; rd_row = 0;
        tick();
        checks++;
        if (rd_err !== 1'b1 || rd_valid !== 1'b0 || rd_data !== prev) begin
            errors++;
            $display("FAIL bad_ch: err=%b valid=%b data=%h expected 1 0 %h", rd_err, rd_valid, rd_data, prev);
        end
        rd_ch = 0; rd_row = 5;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_err !== 1'b1 || rd_valid !== 1'b0 || rd_data !== prev) begin
            errors++;
            $display("FAIL bad_row: err=%b valid=%b data=%h expected 1 0 %h", rd_err, rd_valid, rd_data, prev);
        end
    endtask

    task automatic test_toggle();
        int acc;
        pulse_start();
        checks++;
        if (load_done !== 1'b0 || load_busy !== 1'b1 || w_sum !== 17'sd0) begin
            errors++;
            $display("FAIL restart_done: done=%b busy=%b w_sum=%0d expected 0 1 0", load_done, load_busy, w_sum);
        end
        stream(0, 1'b1, 150, acc);
        checks++;
        if (acc !== 150 || load_done !== 1'b1 || w_sum !== -17'sd75) begin
            errors++;
            $display("FAIL toggle_load: acc=%0d done=%b w_sum=%0d expected 150 1 -75", acc, load_done, w_sum);
        end
        w_valid = 1'b1; w_data = 9'd1;
        #1;
        checks++;
        if (w_ready !== 1'b0) begin
            errors++;
            $display("FAIL done_no_accept: w_ready=%b expected 0", w_ready);
        end
        tick();
        w_valid = 1'b0;
        checks++;
        if (w_sum !== -17'sd75) begin
            errors++;
            $display("FAIL done_sum_hold: w_sum=%0d expected -75", w_sum);
        end
        rd_en = 1'b1; rd_ch = 2; rd_row = 3;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp_row(2, 3)) begin
            errors++;
            $display("FAIL toggle_read: valid=%b data=%h expected 1 %h", rd_valid, rd_data, exp_row(2, 3));
        end
    endtask

    task automatic test_sweep(input string tag);
        int nvalid;
        nvalid = 0;
        for (int i = 0; i < 30; i++) begin
            rd_en = 1'b1; rd_ch = 3'(i / 5); rd_row = 3'(i % 5);
            tick();
            if (rd_valid === 1'b1) nvalid++;
            checks++;
            if (rd_data !== exp_row(i / 5, i % 5)) begin
                errors++;
                $display("FAIL sweep_%s[%0d]: data=%h expected %h", tag, i, rd_data, exp_row(i / 5, i % 5));
            end
        end
        rd_en = 1'b0;
        tick();
        checks++;
        if (nvalid !== 30 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL sweep_%s_count: valid_cycles=%0d trailing=%b expected 30 0", tag, nvalid, rd_valid);
        end
    endtask

    task automatic test_abort_restart();
        int acc;
        pulse_start();
        stream(0, 1'b0, 40, acc);
        start = 1'b1; w_valid = 1'b1; w_data = 9'd100;
        #1;
        checks++;
        if (w_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_ready: w_ready=%b expected 0", w_ready);
        end
        tick();
        start = 1'b0; w_valid = 1'b0;
        checks++;
        if (w_sum !== 17'sd0 || load_busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_clear: w_sum=%0d busy=%b expected 0 1", w_sum, load_busy);
        end
        stream(1, 1'b0, 150, acc);
        checks++;
        if (acc !== 150 || load_done !== 1'b1 || w_sum !== -17'sd450) begin
            errors++;
            $display("FAIL const_load: acc=%0d done=%b w_sum=%0d expected 150 1 -450", acc, load_done, w_sum);
        end
        checks++;
        if (exp_row(4, 2) !== {5{9'h1FD}}) begin
            errors++;
            $display("FAIL const_model: row=%h expected %h", exp_row(4, 2), {5{9'h1FD}});
        end
        test_sweep("const");
    endtask

    task automatic test_reset_mid();
        int acc;
        pulse_start();
        stream(0, 1'b0, 100, acc);
        rst_n = 1'b0;
        tick();
        checks++;
        if ({w_ready, load_busy, load_done, rd_valid, rd_err} !== 5'b0 || w_sum !== 17'sd0
            || rd_data !== 45'd0) begin
            errors++;
            $display("FAIL reset_mid: flags=%b w_sum=%0d rd_data=%h expected all zero",
                     {w_ready, load_busy, load_done, rd_valid, rd_err}, w_sum, rd_data);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (load_busy !== 1'b0 || load_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b done=%b expected 0 0", load_busy, load_done);
        end
        pulse_start();
        stream(0, 1'b0, 150, acc);
        checks++;
        if (acc !== 150 || load_done !== 1'b1 || w_sum !== -17'sd75) begin
            errors++;
            $display("FAIL reload: acc=%0d done=%b w_sum=%0d expected 150 1 -75", acc, load_done, w_sum);
        end
        test_sweep("ramp");
    endtask

    initial begin
        test_reset();
        test_read_before_load();
        test_full_load();
        test_bad_index();
        test_toggle();
        test_abort_restart();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv1_weight_loader.md
Name: conv1_weight_loader

Overview:
- Receives the conv1 kernel weights as a serial stream of signed 9-bit words, 150 in total (6 output channels × 5 rows × 5 cols).
- Stores them in an on-chip buffer and serves one packed 5-tap kernel row per read to the conv1 MAC array.
- This is the synthesizable receive end of the weight stream that the weight generator bench emits.
- Stream order is fixed: channel outermost, then row, then col innermost.

Parameters:
- DW, 9, weight width in bits (two's complement).
- KS, 5, kernel size (rows = cols = KS).
- NCH, 6, number of output channels.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins or restarts a load.
- w_valid  input  1  stream word valid.
- w_data  input  DW  signed weight word.
- w_ready  output  1  loader accepts a word this cycle.
- load_busy  output  1  high while in LOAD.
- load_done  output  1  high in DONE (buffer complete and valid).
- w_sum  output  DW+8  signed running sum of the accepted words of the current load.
- rd_en  input  1  read request.
- rd_ch  input  3  channel index, 0..NCH-1.
- rd_row  input  3  row index, 0..KS-1.
- rd_data  output  KS*DW  packed row; col0 in [KS*DW-1 -: DW], col KS-1 in [DW-1:0].
- rd_valid  output  1  rd_data valid.
- rd_err  output  1  one-cycle pulse on a rejected read.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; col/row/ch counters=0.
  - w_ready=0, load_busy=0, load_done=0, w_sum=0, rd_data=0, rd_valid=0, rd_err=0.
  - Buffer contents are undefined after reset.
- States:
  - IDLE: start -> LOAD.
  - LOAD: start -> LOAD with counters and w_sum cleared (abort and restart). The word offered in that same cycle is not accepted.
  - LOAD: 150th accepted word -> DONE.
  - DONE: start -> LOAD, counters cleared, w_sum cleared, load_done drops the next cycle.
- Handshake:
  - w_ready = (state==LOAD) && !start. It is combinational from state and start.
  - A word is accepted when w_valid && w_ready.
  - w_valid outside LOAD is ignored; there is no storage and no error.
- Accept:
  - Write w_data to buf[ch][row][col].
  - w_sum += sign-extended w_data.
  - col increments; on col==KS-1, col=0 and row increments; on row==KS-1, row=0 and ch increments.
  - Accepting at ch=NCH-1, row=KS-1, col=KS-1 moves to DONE. load_done=1 from the next cycle. Counters return to 0.
- w_sum holds its value in DONE. It does not saturate: a 17-bit width covers 150 × ±256.
- Reads:
  - rd_en in DONE with rd_ch<NCH and rd_row<KS: rd_data updates and rd_valid=1 one cycle later.
  - rd_valid is 0 in any cycle without an accepted read. rd_data holds its last value.
  - Rejected read (state!=DONE, or an index out of range): rd_err=1 one cycle later, rd_valid=0, rd_data unchanged.
  - Reads are single-issue per cycle and fully pipelined, so back-to-back reads return back-to-back data.
- Reset mid-LOAD: returns to IDLE immediately. The partial buffer is not valid; load_done stays 0 until a complete load finishes.

Test Plan:
- Reset, start, then stream 150 words with w_data = n-75 (n=0..149) and w_valid held high -> load_done rises the cycle after the 150th accept, w_sum = -75. Reading ch=0,row=0 gives cols -75,-74,-73,-72,-71. Reading ch=5,row=4 gives 70..74.
- Same stream with w_valid toggled 1-0-1-0 -> identical buffer contents and w_sum. Accept count is exactly 150.
- Read before load (state IDLE, rd_en=1, ch=0,row=0) -> rd_err=1 next cycle, rd_valid=0. In DONE, rd_ch=6 or rd_row=5 -> rd_err=1.
- Start pulsed after 40 accepts, then a full 150-word stream of constant -3 -> w_sum = -450 and every row reads five entries of -3 (0x1FD each).
- rst_n low for 1 cycle after 100 accepts -> all outputs 0 and state IDLE. start plus a full load then completes normally.
- In DONE, rd_en held for 30 cycles sweeping all (ch,row) -> 30 consecutive rd_valid cycles, each row matching the loaded data.
